// File: rtl/dut_result_pkg.sv
// Shared types and sizing helpers for the DUT result FIFO.
// Defaults for data width and depth, plus the pointer width helper.
package dut_result_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] result_t;

  // Address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dut_result_fifo_mem.sv
// Register array for the result FIFO; no reset on contents.
// Ports: clk, write port (we, waddr, wdata), async read (raddr, rdata).
module dut_result_fifo_mem
  import dut_result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dut_result_fifo.sv
// First-word-fall-through FIFO buffering DUT results for the monitor.
// Ports: clk, reset (async, active-low), clear, in_* / out_* handshakes,
// status outputs count, full, empty and sticky overflow.
module dut_result_fifo
  import dut_result_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  // clear wins over any handshake in the same cycle.
  assign push = in_valid && in_ready && !clear;
  assign pop  = out_valid && out_ready && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (in_valid && full) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  dut_result_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_dut_result_fifo.sv
// Self-checking bench for dut_result_fifo against a queue-based model.
// Scenario tasks drive stimulus and compare DUT outputs inline.
module tb_dut_result_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf;

  always #5 clk = ~clk;

  dut_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  // One clock: update the model from the current inputs, then advance.
  task automatic cycle();
    bit m_full;
    bit m_empty;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    if (clear) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (in_valid && m_full) m_ovf = 1'b1;
      if (out_ready && !m_empty) void'(q.pop_front());
      if (in_valid && !m_full) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0;
    in_valid = 0;
    out_ready = 0;
    in_data = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    q.delete();
    m_ovf = 0;
    #6;
    reset = 1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
        in_ready !== 1'b1 || out_valid !== 1'b0 ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: cnt=%0d e=%b f=%b ir=%b ov=%b of=%b",
               count, empty, full, in_ready, out_valid, overflow);
    end
  endtask

  task automatic test_single();
    idle();
    in_valid = 1;
    in_data = 32'hDEAD_BEEF;
    cycle();
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF ||
          count !== 4'd1) begin
        failures++;
        $display("FAIL single: ov=%b data=%h cnt=%0d want 1 deadbeef 1",
                 out_valid, out_data, count);
      end
      cycle();
    end
    out_ready = 1;
    cycle();
    out_ready = 0;
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: empty=%b ov=%b want 1 0",
               empty, out_valid);
    end
  endtask

  task automatic test_fill_wrap();
    int want;
    idle();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1;
      in_data = i;
      cycle();
    end
    in_valid = 0;
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 4'd8) begin
      failures++;
      $display("FAIL fill: full=%b ir=%b cnt=%0d want 1 0 8",
               full, in_ready, count);
    end
    want = 1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data !== DW'(want)) begin
        failures++;
        $display("FAIL wrap_pop: got %0d want %0d", out_data, want);
      end
      want++;
      cycle();
    end
    out_ready = 0;
    for (int i = 9; i <= 11; i++) begin
      in_valid = 1;
      in_data = i;
      cycle();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(want)) begin
        failures++;
        $display("FAIL wrap_order: v=%b got %0d want %0d",
                 out_valid, out_data, want);
      end
      want++;
      cycle();
    end
    out_ready = 0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty: empty=%b want 1", empty);
    end
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1;
      in_data = 32'h1000 + i;
      cycle();
    end
    in_valid = 1;
    in_data = 32'h55;
    cycle();
    in_valid = 0;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL overflow: of=%b cnt=%0d want 1 8", overflow, count);
    end
    cycle();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: of=%b want 1", overflow);
    end
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== 32'h1000 + i) begin
        failures++;
        $display("FAIL overflow_data: got %h want %h",
                 out_data, 32'h1000 + i);
      end
      cycle();
    end
    out_ready = 0;
    in_valid = 1;
    in_data = 32'h77;
    clear = 1;
    cycle();
    idle();
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL clear: cnt=%0d of=%b e=%b want 0 0 1",
               count, overflow, empty);
    end
  endtask

  task automatic test_concurrent();
    logic [DW-1:0] exp_seq[$];
    idle();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = $urandom;
      exp_seq.push_back(in_data);
      cycle();
    end
    for (int i = 0; i < 10; i++) exp_seq.push_back(100 + i);
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 100 + i;
      checks++;
      if (count !== 4'd4 || out_data !== exp_seq[i]) begin
        failures++;
        $display("FAIL concurrent[%0d]: cnt=%0d data=%h want 4 %h",
                 i, count, out_data, exp_seq[i]);
      end
      cycle();
    end
    idle();
    checks++;
    if (count !== 4'd4 || out_data !== 32'd106) begin
      failures++;
      $display("FAIL concurrent_end: cnt=%0d data=%0d want 4 106",
               count, out_data);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    clear = 1;
    cycle();
    clear = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = 32'hA0 + i;
      cycle();
    end
    in_valid = 0;
    #2;
    reset = 0;
    q.delete();
    m_ovf = 0;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: cnt=%0d e=%b want 0 1", count, empty);
    end
    #2;
    reset = 1;
    @(posedge clk);
    #1;
    in_valid = 1;
    in_data = 32'h1;
    cycle();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1 || count !== 4'd1) begin
      failures++;
      $display("FAIL post_reset: v=%b data=%h cnt=%0d want 1 1 1",
               out_valid, out_data, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = $urandom;
      clear = ($urandom_range(0, 59) == 0);
      cycle();
      checks++;
      if (count !== 4'(q.size()) ||
          empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) ||
          in_ready !== (q.size() != DEPTH) ||
          out_valid !== (q.size() != 0) ||
          overflow !== m_ovf) begin
        failures++;
        $display("FAIL random_flags[%0d]: cnt=%0d of=%b want %0d %b",
                 i, count, overflow, q.size(), m_ovf);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_data !== q[0]) begin
          failures++;
          $display("FAIL random_data[%0d]: got %h want %h",
                   i, out_data, q[0]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_concurrent();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
